ras_recoverable: RTL and testbench

Parametrised return address stack (RAS) for the fetch predictor complex, sized by depth and target width. Pushes on calls, pops on returns, and supports a replace operation (pop and push in the same cycle). Also supports single-cycle restore of the top pointer and occupancy from a checkpoint taken at branch prediction time. Sits beside the BTB/UPCT in the fetch stage and feeds the predicted return target; the checkpoint snapshot (`ras_index`, `ras_count`) travels with the branch to the backend and comes back on a mispredict.

---
 rtl/core_types_pkg.sv | 25 ++
 rtl/ras_recoverable_if.sv | 51 +++++
 rtl/mod_wrap_ctr.sv | 23 ++
 rtl/ras_recoverable.sv | 138 +++++++++++++
 tb/tb_ras_recoverable.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_types_pkg.sv
// -----------------------------------------------------------------------------
// core_types_pkg
// Shared fetch-predictor types and default sizing for the return address
// stack. Backend checkpoint storage reuses ras_checkpoint_t so the snapshot
// taken at prediction time has the same layout as the restore request.
// Optional feature macro: RAS_PERF_EN (overflow/underflow perf counters).
// -----------------------------------------------------------------------------
package core_types_pkg;

    localparam int RAS_ENTRIES      = 8;
    localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
    localparam int RAS_COUNT_WIDTH  = $clog2(RAS_ENTRIES + 1);
    localparam int RAS_TARGET_WIDTH = 31;
    localparam int RAS_PERF_WIDTH   = 16;

    typedef logic [RAS_INDEX_WIDTH-1:0]  ras_index_t;
    typedef logic [RAS_COUNT_WIDTH-1:0]  ras_count_t;
    typedef logic [RAS_TARGET_WIDTH-1:0] ras_target_t;

    typedef struct packed {
        ras_index_t index;
        ras_count_t count;
    } ras_checkpoint_t;

endpackage

// File: rtl/ras_recoverable_if.sv
// -----------------------------------------------------------------------------
// ras_recoverable_if
// Bundle of the RAS request/response signals.
//   master : fetch side, drives push/pop/restore requests, reads the top.
//   slave  : the RAS itself.
// Signals: push_valid, push_target, pop_valid, restore_valid, restore_index,
//          restore_count (requests); ras_valid, ras_target, ras_index,
//          ras_count (registered state). With RAS_PERF_EN also
//          overflow_count / underflow_count.
// -----------------------------------------------------------------------------
interface ras_recoverable_if
    import core_types_pkg::*;
#(
    parameter int RAS_INDEX_WIDTH  = core_types_pkg::RAS_INDEX_WIDTH,
    parameter int RAS_COUNT_WIDTH  = core_types_pkg::RAS_COUNT_WIDTH,
    parameter int RAS_TARGET_WIDTH = core_types_pkg::RAS_TARGET_WIDTH
);
    logic                        push_valid;
    logic [RAS_TARGET_WIDTH-1:0] push_target;
    logic                        pop_valid;
    logic                        restore_valid;
    logic [RAS_INDEX_WIDTH-1:0]  restore_index;
    logic [RAS_COUNT_WIDTH-1:0]  restore_count;
    logic                        ras_valid;
    logic [RAS_TARGET_WIDTH-1:0] ras_target;
    logic [RAS_INDEX_WIDTH-1:0]  ras_index;
    logic [RAS_COUNT_WIDTH-1:0]  ras_count;
`ifdef RAS_PERF_EN
    logic [RAS_PERF_WIDTH-1:0]   overflow_count;
    logic [RAS_PERF_WIDTH-1:0]   underflow_count;
`endif

    modport master (
        output push_valid, push_target, pop_valid,
        output restore_valid, restore_index, restore_count,
`ifdef RAS_PERF_EN
        input  overflow_count, underflow_count,
`endif
        input  ras_valid, ras_target, ras_index, ras_count
    );

    modport slave (
        input  push_valid, push_target, pop_valid,
        input  restore_valid, restore_index, restore_count,
`ifdef RAS_PERF_EN
        output overflow_count, underflow_count,
`endif
        output ras_valid, ras_target, ras_index, ras_count
    );

endinterface

// File: rtl/mod_wrap_ctr.sv
// -----------------------------------------------------------------------------
// mod_wrap_ctr
// Combinational modulo-N increment/decrement of a pointer. The wrap is an
// explicit compare against N-1 / 0, so N need not be a power of two.
//   val_i : current pointer
//   inc_o : val_i == N-1 ? 0 : val_i+1
//   dec_o : val_i == 0   ? N-1 : val_i-1
// -----------------------------------------------------------------------------
module mod_wrap_ctr #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [W-1:0] val_i,
    output logic [W-1:0] inc_o,
    output logic [W-1:0] dec_o
);
    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    assign inc_o = (val_i == LAST) ? '0   : val_i + ONE;
    assign dec_o = (val_i == '0)   ? LAST : val_i - ONE;

endmodule

// File: rtl/ras_recoverable.sv
// -----------------------------------------------------------------------------
// ras_recoverable
// Return address stack with checkpoint restore for the fetch predictor.
// Circular array of RAS_ENTRIES targets; top points at the newest entry.
// Priority per cycle: restore > replace (push&pop) > push > pop.
// Ports:
//   CLK    : clock, all state on rising edge
//   RST    : asynchronous active-high reset
//   ras_if : ras_recoverable_if.slave (requests in, registered state out)
// Optional feature macro: RAS_PERF_EN adds 16-bit saturating overflow and
// underflow event counters on the interface.
// -----------------------------------------------------------------------------
module ras_recoverable
    import core_types_pkg::*;
#(
    parameter int RAS_ENTRIES      = core_types_pkg::RAS_ENTRIES,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_COUNT_WIDTH  = $clog2(RAS_ENTRIES + 1),
    parameter int RAS_TARGET_WIDTH = core_types_pkg::RAS_TARGET_WIDTH
) (
    input  logic          CLK,
    input  logic          RST,
    ras_recoverable_if.slave ras_if
);
    localparam logic [RAS_COUNT_WIDTH-1:0] FULL  = RAS_COUNT_WIDTH'(RAS_ENTRIES);
    localparam logic [RAS_COUNT_WIDTH-1:0] C_ONE = RAS_COUNT_WIDTH'(1);

    logic [RAS_TARGET_WIDTH-1:0] array_q [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  top_q, top_d;
    logic [RAS_COUNT_WIDTH-1:0]  count_q, count_d;
    logic [RAS_INDEX_WIDTH-1:0]  top_inc, top_dec;

    logic                        wr_en;
    logic [RAS_INDEX_WIDTH-1:0]  wr_addr;
`ifdef RAS_PERF_EN
    logic                        ovf_evt, unf_evt;
    logic [RAS_PERF_WIDTH-1:0]   ovf_cnt_q, unf_cnt_q;
`endif

    mod_wrap_ctr #(
        .N (RAS_ENTRIES),
        .W (RAS_INDEX_WIDTH)
    ) u_top_ctr (
        .val_i (top_q),
        .inc_o (top_inc),
        .dec_o (top_dec)
    );

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = top_q;
`ifdef RAS_PERF_EN
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
`endif
        if (ras_if.restore_valid) begin
            // Array is left alone: entries above the checkpointed top may be
            // stale but are exactly what the predictor saw at snapshot time.
            top_d   = ras_if.restore_index;
            count_d = (ras_if.restore_count > FULL) ? FULL : ras_if.restore_count;
        end else if (ras_if.push_valid && ras_if.pop_valid) begin
            wr_en = 1'b1;
            if (count_q == '0) begin
                count_d = C_ONE;
            end
        end else if (ras_if.push_valid) begin
            top_d   = top_inc;
            wr_en   = 1'b1;
            wr_addr = top_inc;
            if (count_q == FULL) begin
                // Oldest entry is overwritten; occupancy stays pinned at full.
`ifdef RAS_PERF_EN
                ovf_evt = 1'b1;
`endif
            end else begin
                count_d = count_q + C_ONE;
            end
        end else if (ras_if.pop_valid) begin
            // Pointer still moves on underflow so a later push refills the
            // slot the fetch side expects.
            top_d = top_dec;
            if (count_q == '0) begin
`ifdef RAS_PERF_EN
                unf_evt = 1'b1;
`endif
            end else begin
                count_d = count_q - C_ONE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                array_q[i] <= '0;
            end
        end else if (wr_en) begin
            array_q[wr_addr] <= ras_if.push_target;
        end
    end

`ifdef RAS_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            if (ovf_evt && (ovf_cnt_q != '1)) begin
                ovf_cnt_q <= ovf_cnt_q + 1'b1;
            end
            if (unf_evt && (unf_cnt_q != '1)) begin
                unf_cnt_q <= unf_cnt_q + 1'b1;
            end
        end
    end

    assign ras_if.overflow_count  = ovf_cnt_q;
    assign ras_if.underflow_count = unf_cnt_q;
`endif

    assign ras_if.ras_valid  = (count_q != '0);
    assign ras_if.ras_target = array_q[top_q];
    assign ras_if.ras_index  = top_q;
    assign ras_if.ras_count  = count_q;

endmodule

// File: tb/tb_ras_recoverable.sv
// -----------------------------------------------------------------------------
// tb_ras_recoverable
// Directed scenarios followed by random traffic on a 6-entry RAS, checked
// against a simple array/modulo reference model.
// Optional feature macro: RAS_PERF_EN (also checks the perf counters).
// -----------------------------------------------------------------------------
module tb_ras_recoverable;
    localparam int N  = 6;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam int TW = 31;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    ras_recoverable_if #(
        .RAS_INDEX_WIDTH  (IW),
        .RAS_COUNT_WIDTH  (CW),
        .RAS_TARGET_WIDTH (TW)
    ) ifc ();

    ras_recoverable #(
        .RAS_ENTRIES      (N),
        .RAS_INDEX_WIDTH  (IW),
        .RAS_COUNT_WIDTH  (CW),
        .RAS_TARGET_WIDTH (TW)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .ras_if (ifc)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model
    logic [TW-1:0] m_arr [N];
    int            m_top;
    int            m_cnt;
    int            m_ovf;
    int            m_unf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_arr[i] = '0;
        m_top = 0;
        m_cnt = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic m_step(input bit pu, input logic [TW-1:0] pt, input bit po,
                          input bit rs, input int ri, input int rc);
        if (rs) begin
            m_top = ri;
            m_cnt = (rc > N) ? N : rc;
        end else if (pu && po) begin
            m_arr[m_top] = pt;
            if (m_cnt == 0) m_cnt = 1;
        end else if (pu) begin
            if (m_cnt == N) begin
                if (m_ovf < 65535) m_ovf++;
            end else begin
                m_cnt++;
            end
            m_top = (m_top + 1) % N;
            m_arr[m_top] = pt;
        end else if (po) begin
            if (m_cnt == 0) begin
                if (m_unf < 65535) m_unf++;
            end else begin
                m_cnt--;
            end
            m_top = (m_top + N - 1) % N;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  64'(ifc.ras_valid),  64'(m_cnt != 0));
        chk({tag, ".target"}, 64'(ifc.ras_target), 64'(m_arr[m_top]));
        chk({tag, ".index"},  64'(ifc.ras_index),  64'(m_top));
        chk({tag, ".count"},  64'(ifc.ras_count),  64'(m_cnt));
`ifdef RAS_PERF_EN
        chk({tag, ".ovf"},    64'(ifc.overflow_count),  64'(m_ovf));
        chk({tag, ".unf"},    64'(ifc.underflow_count), 64'(m_unf));
`endif
    endtask

    task automatic idle();
        ifc.push_valid    = 1'b0;
        ifc.push_target   = '0;
        ifc.pop_valid     = 1'b0;
        ifc.restore_valid = 1'b0;
        ifc.restore_index = '0;
        ifc.restore_count = '0;
    endtask

    // one operation: drive, clock, update model, check 1 ns after the edge
    task automatic cyc(input bit pu, input logic [TW-1:0] pt, input bit po,
                       input bit rs, input int ri, input int rc, input string tag);
        ifc.push_valid    = pu;
        ifc.push_target   = pt;
        ifc.pop_valid     = po;
        ifc.restore_valid = rs;
        ifc.restore_index = IW'(ri);
        ifc.restore_count = CW'(rc);
        @(posedge CLK);
        m_step(pu, pt, po, rs, ri, rc);
        #1;
        check_all(tag);
        idle();
    endtask

    task automatic push(input logic [TW-1:0] pt, input string tag);
        cyc(1'b1, pt, 1'b0, 1'b0, 0, 0, tag);
    endtask

    task automatic pop(input string tag);
        cyc(1'b0, '0, 1'b1, 1'b0, 0, 0, tag);
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        m_reset();
        check_all(tag);
        RST = 1'b0;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        m_reset();
        check_all("reset");
        RST = 1'b0;

        // basic push/pop
        push(31'h100, "t1.push");
        push(31'h200, "t1.push");
        push(31'h300, "t1.push");
        chk("t1.target_lit", 64'(ifc.ras_target), 64'h300);
        chk("t1.count_lit",  64'(ifc.ras_count),  64'd3);
        chk("t1.index_lit",  64'(ifc.ras_index),  64'd3);
        pop("t1.pop");
        pop("t1.pop");
        chk("t1.after_pop_lit", 64'(ifc.ras_target), 64'h100);

        // overflow and wrap on a non-power-of-2 depth
        do_reset("t2.reset");
        for (int i = 1; i <= 8; i++) push(TW'(i), "t2.push");
        chk("t2.top_wrap_lit", 64'(ifc.ras_index), 64'd2);
        chk("t2.target_lit",   64'(ifc.ras_target), 64'd8);
        for (int i = 0; i < 6; i++) pop("t2.pop");
        chk("t2.empty_lit", 64'(ifc.ras_valid), 64'd0);

        // underflow then refill
        do_reset("t3.reset");
        pop("t3.underflow");
        chk("t3.top_lit", 64'(ifc.ras_index), 64'd5);
        push(31'hAA, "t3.push");
        chk("t3.target_lit", 64'(ifc.ras_target), 64'hAA);

        // replace, including replace at empty
        do_reset("t4.reset");
        push(31'h10, "t4.push");
        cyc(1'b1, 31'h20, 1'b1, 1'b0, 0, 0, "t4.replace");
        do_reset("t4.reset2");
        cyc(1'b1, 31'h44, 1'b1, 1'b0, 0, 0, "t4.replace_empty");

        // checkpoint restore with push/pop also asserted
        do_reset("t5.reset");
        push(31'h11, "t5.push");
        push(31'h22, "t5.push");
        push(31'h30, "t5.push");
        pop("t5.pop");
        pop("t5.pop");
        cyc(1'b1, 31'h7777, 1'b1, 1'b1, 2, 2, "t5.restore");
        chk("t5.stale_lit", 64'(ifc.ras_target), 64'h22);
        cyc(1'b0, '0, 1'b0, 1'b1, 4, 7, "t5.restore_clamp");

        // asynchronous reset between edges
        do_reset("t6.reset");
        for (int i = 0; i < 4; i++) push(TW'(32'h500 + i), "t6.push");
        #2;
        ifc.push_valid  = 1'b1;
        ifc.push_target = 31'h1234;
        RST = 1'b1;
        #1;
        m_reset();
        check_all("t6.async_rst");
        @(posedge CLK);
        #1;
        check_all("t6.rst_held");
        RST = 1'b0;
        idle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit            rs, pu, po;
            logic [TW-1:0] pt;
            rs = ($urandom_range(0, 99) < 8);
            pu = 1'($urandom);
            po = 1'($urandom);
            pt = TW'($urandom);
            cyc(pu, pt, po, rs, int'($urandom_range(0, N - 1)),
                int'($urandom_range(0, 7)), "rand");
        end

`ifdef RAS_PERF_EN
        // saturation of the overflow counter
        do_reset("t7.reset");
        ifc.push_valid = 1'b1;
        for (int i = 0; i < 65545; i++) begin
            ifc.push_target = TW'(i);
            @(posedge CLK);
            m_step(1'b1, TW'(i), 1'b0, 1'b0, 0, 0);
        end
        #1;
        idle();
        check_all("t7.sat");
        chk("t7.ovf_lit", 64'(ifc.overflow_count), 64'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
